// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared switch-count and debounce constants for main and io
package sw_debounce_pkg;

  // Board switch count (SW[17:0]).
  localparam int SW_COUNT_DEF = 18;

  // 20 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  // Largest debounce constant the 24-bit counter range supports.
  localparam int DEBOUNCE_CYCLES_MAX = (1 << 24) - 1;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchronizer, stability counter and debounced output flop
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_accept
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  // The synchronized level disagrees with the accepted level.
  assign w_differs = (r_sync2 != r_stable);

  // The disagreement has lasted DEBOUNCE_CYCLES cycles, including this one.
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Two-flop synchronizer; reset to the output reset value so release is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle or an accept restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_differs || w_accept) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Accepted level follows the synchronizer only once the count completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= RESET_VAL;
    end else if (w_accept) begin
      r_stable <= r_sync2;
    end
  end

  assign o_stable = r_stable;
  assign o_accept = w_accept;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - N-bit switch debouncer with optional edge/sticky flags (SW_DEBOUNCE_EDGE_EN)
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int           N               = SW_COUNT_DEF,
  parameter int           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [N-1:0] RESET_VAL       = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  input  logic         clr,
  output logic [N-1:0] sw_out,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic [N-1:0] sw_changed
);

  // One-cycle strobe per bit: that bit's sw_out takes the opposite value on this edge.
  logic [N-1:0] w_accept;

  for (genvar g = 0; g < N; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL[g])
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (sw_in[g]),
      .o_stable(sw_out[g]),
      .o_accept(w_accept[g])
    );
  end

`ifdef SW_DEBOUNCE_EDGE_EN

  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;
  logic [N-1:0] r_changed;

  // An accept always flips the bit, so the current sw_out gives the edge direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_accept & ~sw_out;
      r_fall <= w_accept &  sw_out;
    end
  end

  // Sticky change flags; a new change on a bit beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= '0;
    end else begin
      r_changed <= (r_changed & ~{N{clr}}) | w_accept;
    end
  end

  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = r_changed;

`else

  // Edge and sticky logic absent: clr and the accept strobes go nowhere.
  logic [N:0] w_unused_edge;
  assign w_unused_edge = {clr, w_accept};

  assign sw_rise    = '0;
  assign sw_fall    = '0;
  assign sw_changed = '0;

`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce (N=4, DEBOUNCE_CYCLES=4)
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int LAT = 6;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_in;
  logic       clr;
  logic [3:0] sw_out;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic [3:0] sw_changed;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  sw_debounce #(
    .N              (4),
    .DEBOUNCE_CYCLES(4),
    .RESET_VAL      (4'b0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .clr       (clr),
    .sw_out    (sw_out),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ef(input logic [3:0] v);
    return EDGE ? v : 4'b0000;
  endfunction

  task automatic push(input int c, input logic [3:0] o, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] ch);
    exp_t e;
    e.cyc  = c;
    e.out  = o;
    e.rise = ef(r);
    e.fall = ef(f);
    e.chg  = ef(ch);
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every sw_out update is matched against the next scoreboard entry.
  initial begin
    logic [3:0] prev;
    exp_t       e;
    prev = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = sw_out;
      end else if (sw_out !== prev) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_update: got %0h expected %0h (cycle %0d)", sw_out, prev, cyc);
        end else begin
          e = q.pop_front();
          chk("update_cycle", cyc, e.cyc);
          chk("update_out", sw_out, e.out);
          chk("update_rise", sw_rise, e.rise);
          chk("update_fall", sw_fall, e.fall);
          chk("update_changed", sw_changed, e.chg);
        end
        prev = sw_out;
      end else begin
        chk("no_pulse", {sw_rise, sw_fall}, 8'h00);
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    rst_n = 1'b0;
    sw_in = 4'b0000;
    clr   = 1'b0;
    tick(3);
    chk("reset_out", sw_out, 4'b0000);
    chk("reset_rise", sw_rise, 4'b0000);
    chk("reset_fall", sw_fall, 4'b0000);
    chk("reset_changed", sw_changed, 4'b0000);
    rst_n = 1'b1;
    tick(3);

    // Clean rising step on bit0.
    sw_in = 4'b0001;
    push(cyc + LAT, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tick(5);
    chk("step_not_early", sw_out, 4'b0000);
    tick(5);

    // Three-cycle low glitch on bit0 must be rejected.
    sw_in = 4'b0000;
    tick(3);
    sw_in = 4'b0001;
    tick(10);
    chk("glitch_out", sw_out, 4'b0001);

    // Falling step back to zero, then clear the sticky flags.
    sw_in = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    tick(8);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    chk("clr_changed", sw_changed, 4'b0000);

    // Two bits rise together.
    sw_in = 4'b1010;
    push(cyc + LAT, 4'b1010, 4'b1010, 4'b0000, 4'b1010);
    tick(10);

    // Bit2 update coincides with clr: bit2 survives, bits 1 and 3 are cleared.
    sw_in = 4'b1110;
    push(cyc + LAT, 4'b1110, 4'b0100, 4'b0000, 4'b0100);
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    chk("clr_race_changed", sw_changed, ef(4'b0100));

    // Reset in the middle of a pending change on bit3.
    sw_in = 4'b0110;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("midreset_out", sw_out, 4'b0000);
    chk("midreset_changed", sw_changed, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    r = cyc;
    push(r + LAT, 4'b0110, 4'b0110, 4'b0000, 4'b0110);
    tick(5);
    chk("postreset_not_early", sw_out, 4'b0000);
    tick(5);
    chk("final_out", sw_out, 4'b0110);
    chk("final_changed", sw_changed, ef(4'b0110));

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter N, default 18, number of switch/key inputs debounced (matches board SW width).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable clk cycles required before accepting a change (20 ms at 50 MHz); legal range 1..2^24-1.
REQ-003 SHALL have parameter RESET_VAL, default all-zero N bits, value of debounced outputs after reset.
REQ-004 SHALL have port clk  input  1  single clock (CLOCK_50 domain).
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sw_in  input  N  raw asynchronous switch levels from board pins.
REQ-007 SHALL have port clr  input  1  one-cycle pulse clearing the sticky change register (driven by io on store to its status address).
REQ-008 SHALL have port sw_out  output  N  debounced switch levels, fed to io sw_in.
REQ-009 SHALL have port sw_rise  output  N  one-cycle pulse per bit on accepted 0->1 change.
REQ-010 SHALL have port sw_fall  output  N  one-cycle pulse per bit on accepted 1->0 change.
REQ-011 SHALL have port sw_changed  output  N  sticky per-bit flag, set on any accepted change.

Function
REQ-012 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES+1), independent of all other bits.
REQ-014 Per bit: while sync2 == sw_out the counter SHALL be 0.
REQ-015 Per bit: while sync2 != sw_out and counter < DEBOUNCE_CYCLES-1, counter SHALL increment by 1 each cycle.
REQ-016 Per bit: when sync2 != sw_out and counter == DEBOUNCE_CYCLES-1, sw_out SHALL take sync2 and counter SHALL return to 0 at that edge.
REQ-017 Latency: a clean input step SHALL appear on sw_out exactly 2+DEBOUNCE_CYCLES clk edges after the first edge sampling the new level.
REQ-018 A glitch with sync2 differing for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL NOT change sw_out; counter restarts from 0 on the next differing cycle.
REQ-019 DEBOUNCE_CYCLES == 1 SHALL accept a change on the first cycle sync2 differs (pure synchronizer, latency 3).
REQ-020 sw_rise/sw_fall SHALL be registered and high for exactly the one cycle in which sw_out shows the new value.
REQ-021 sw_changed bit SHALL set in the same cycle sw_out updates and hold until clr.
REQ-022 clr SHALL clear all sw_changed bits on the next edge; a simultaneous set on a bit SHALL win over clr for that bit.
REQ-023 Any number of bits SHALL be able to update in the same cycle without interaction.

Reset
REQ-024 While rst_n is low: sync1, sync2 and sw_out = RESET_VAL; counters = 0; sw_rise, sw_fall, sw_changed = 0.
REQ-025 Reset asserted mid-count SHALL abandon the count; after release a pending level difference SHALL require a full 2+DEBOUNCE_CYCLES again.
REQ-026 No rise/fall pulse or sticky flag SHALL be produced by reset release itself.

Configuration
REQ-027 Macro SW_DEBOUNCE_EDGE_EN defined: sw_rise, sw_fall, sw_changed and clr behave as REQ-020..022.
REQ-028 Macro SW_DEBOUNCE_EDGE_EN undefined: sw_rise, sw_fall, sw_changed SHALL be tied 0, clr ignored, no edge/sticky flops synthesized; sw_out behaviour unchanged.

Structure
REQ-029 Shared package SHALL hold the default switch count (18) and default debounce constant (1000000) used by main and io.
REQ-030 One sub-module debounce_bit (synchronizer + counter + stable flop for one bit) SHALL be instantiated N times via generate; edge/sticky logic stays in sw_debounce.

Verification (N=4, DEBOUNCE_CYCLES=4, RESET_VAL=0)
REQ-031 Reset, then sw_in=4'b0001 held -> sw_out=4'b0001 exactly 6 edges later, sw_rise=4'b0001 for that one cycle, sw_changed=4'b0001.
REQ-032 sw_out=4'b0001, bit0 glitch low for 3 cycles -> sw_out stays 4'b0001, no sw_fall.
REQ-033 sw_in 4'b0000->4'b1010 at once -> sw_out=4'b1010 same cycle, sw_rise=4'b1010, both sticky bits set.
REQ-034 clr pulse in the same cycle bit2 update occurs, bit1 previously sticky -> sw_changed=4'b0100 afterwards.
REQ-035 rst_n low during count 2 of a pending change, released, input held -> sw_out updates 6 edges after release; no pulse at release.
REQ-036 Build without SW_DEBOUNCE_EDGE_EN, repeat REQ-031 -> identical sw_out timing, sw_rise/sw_fall/sw_changed remain 0.
